mrt_dest_reader: RTL and testbench



---
 rtl/mrt_pkg.sv | 21 ++
 rtl/mrt_lsb_find.sv | 32 +++
 rtl/mrt_dest_reader.sv | 142 ++++++++++++++
 tb/tb_mrt_dest_reader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrt_pkg.sv
// Shared definitions for the multi-render-target (MRT) memory path.
// Holds the default geometry shared by the read and write sides, the
// reader FSM state type and a helper for index widths.
package mrt_pkg;

  localparam int unsigned NumRtDefault     = 4;
  localparam int unsigned DataWidthDefault = 128;
  localparam int unsigned AddrWidthDefault = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDone  = 2'd2
  } mrt_state_e;

  // Width of an index into n lanes; a single lane still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mrt_lsb_find.sv
// Combinational lowest-set-bit finder.
// Ports:
//   vec_i    : input vector
//   onehot_o : one-hot mask of the lowest set bit (zero if none)
//   idx_o    : index of the lowest set bit (zero if none)
//   any_o    : at least one bit set
module mrt_lsb_find
  import mrt_pkg::*;
#(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0]               vec_i,
  output logic [Width-1:0]               onehot_o,
  output logic [idx_width(Width)-1:0]    idx_o,
  output logic                           any_o
);

  localparam int unsigned IdxW = idx_width(Width);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = vec_i & (~vec_i + Width'(1));
  assign any_o    = |vec_i;

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/mrt_dest_reader.sv
// Destination-color fetch unit for the MRT blend path.
// Accepts a fragment (per-RT addresses + enable mask), issues one read per
// enabled RT in ascending RT order on a shared read port, gathers the
// in-order responses per lane and hands the result to the blend stage.
// Ports:
//   clk, rstn         : clock, synchronous active-low reset
//   req_*_i/_o        : fragment request handshake, addresses, mask
//   mem_rd_*          : read command port (valid/ready, address)
//   mem_rsp_*_i       : in-order read responses, no backpressure
//   out_*             : gathered colors, mask copy, valid/ready
//   rsp_err_o         : sticky flag, response arrived with none outstanding
module mrt_dest_reader
  import mrt_pkg::*;
#(
  parameter int unsigned NumRt     = NumRtDefault,
  parameter int unsigned DataWidth = DataWidthDefault,
  parameter int unsigned AddrWidth = AddrWidthDefault
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [NumRt*AddrWidth-1:0]    req_addr_i,
  input  logic [NumRt-1:0]              req_mask_i,
  output logic                          mem_rd_valid_o,
  output logic [AddrWidth-1:0]          mem_rd_addr_o,
  input  logic                          mem_rd_ready_i,
  input  logic                          mem_rsp_valid_i,
  input  logic [DataWidth-1:0]          mem_rsp_data_i,
  output logic                          out_valid_o,
  output logic [NumRt*DataWidth-1:0]    out_data_o,
  output logic [NumRt-1:0]              out_mask_o,
  input  logic                          out_ready_i,
  output logic                          rsp_err_o
);

  localparam int unsigned IdxW = idx_width(NumRt);

  mrt_state_e                    state_q, state_d;
  logic [NumRt*AddrWidth-1:0]    addr_q, addr_d;
  logic [NumRt-1:0]              mask_q, mask_d;
  logic [NumRt-1:0]              iss_rem_q, iss_rem_d;
  logic [NumRt-1:0]              rsp_rem_q, rsp_rem_d;
  logic [NumRt*DataWidth-1:0]    out_data_q, out_data_d;
  logic                          rsp_err_q, rsp_err_d;

  logic [NumRt-1:0] iss_oh, rsp_oh;
  logic [IdxW-1:0]  iss_idx, rsp_idx;
  logic             iss_any, rsp_any;

  mrt_lsb_find #(
    .Width (NumRt)
  ) u_iss_find (
    .vec_i    (iss_rem_q),
    .onehot_o (iss_oh),
    .idx_o    (iss_idx),
    .any_o    (iss_any)
  );

  mrt_lsb_find #(
    .Width (NumRt)
  ) u_rsp_find (
    .vec_i    (rsp_rem_q),
    .onehot_o (rsp_oh),
    .idx_o    (rsp_idx),
    .any_o    (rsp_any)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    mask_d         = mask_q;
    iss_rem_d      = iss_rem_q;
    rsp_rem_d      = rsp_rem_q;
    out_data_d     = out_data_q;
    rsp_err_d      = rsp_err_q;
    req_ready_o    = 1'b0;
    mem_rd_valid_o = 1'b0;
    mem_rd_addr_o  = '0;
    out_valid_o    = 1'b0;

    // rsp_rem is only non-zero in FETCH, so this covers IDLE and DONE too.
    if (mem_rsp_valid_i && !rsp_any) rsp_err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d     = req_addr_i;
          mask_d     = req_mask_i;
          iss_rem_d  = req_mask_i;
          rsp_rem_d  = req_mask_i;
          out_data_d = '0;
          state_d    = (req_mask_i == '0) ? StDone : StFetch;
        end
      end

      StFetch: begin
        mem_rd_valid_o = iss_any;
        if (iss_any) mem_rd_addr_o = addr_q[AddrWidth*iss_idx +: AddrWidth];
        if (iss_any && mem_rd_ready_i) iss_rem_d = iss_rem_q & ~iss_oh;
        if (mem_rsp_valid_i && rsp_any) begin
          out_data_d[DataWidth*rsp_idx +: DataWidth] = mem_rsp_data_i;
          rsp_rem_d = rsp_rem_q & ~rsp_oh;
          if ((rsp_rem_q & ~rsp_oh) == '0) state_d = StDone;
        end
      end

      StDone: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      mask_q     <= '0;
      iss_rem_q  <= '0;
      rsp_rem_q  <= '0;
      out_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      iss_rem_q  <= iss_rem_d;
      rsp_rem_q  <= rsp_rem_d;
      out_data_q <= out_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign out_data_o = out_data_q;
  assign out_mask_o = mask_q;
  assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_mrt_dest_reader.sv
// Bench for mrt_dest_reader: directed fragments against a fragment-level
// model (expected command list, expected gathered colors, outstanding count).
module tb_mrt_dest_reader;

  localparam int NR = 4;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int OW = NR * DW;

  logic            clk = 1'b0;
  logic            rstn;
  logic            req_valid, req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   req_mask;
  logic            mem_rd_valid, mem_rd_ready;
  logic [AW-1:0]   mem_rd_addr;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic            out_valid, out_ready, rsp_err;
  logic [OW-1:0]   out_data;
  logic [NR-1:0]   out_mask;

  always #5 clk = ~clk;

  mrt_dest_reader #(
    .NumRt     (NR),
    .DataWidth (DW),
    .AddrWidth (AW)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_mask_i      (req_mask),
    .mem_rd_valid_o  (mem_rd_valid),
    .mem_rd_addr_o   (mem_rd_addr),
    .mem_rd_ready_i  (mem_rd_ready),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_data_i  (mem_rsp_data),
    .out_valid_o     (out_valid),
    .out_data_o      (out_data),
    .out_mask_o      (out_mask),
    .out_ready_i     (out_ready),
    .rsp_err_o       (rsp_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {4{a ^ 32'hDEAD0000}};
  endfunction

  // Memory model: fixed latency, in-order, optional command stall.
  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } rsp_t;
  rsp_t mem_q[$];
  rsp_t r_tmp;

  int   cyc = 0;
  int   mem_lat = 1;
  int   stall_at = -1;
  int   stall_left = 0;
  logic inject = 1'b0;
  logic armed = 1'b0;

  // Fragment-level model state.
  logic          busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [NR-1:0] m_mask = '0, last_mask = '0;
  logic [OW-1:0] m_out = '0, last_out = '0;
  logic [AW-1:0] cmd_q[$];
  logic [AW-1:0] prev_addr = '0;
  logic          prev_stall = 1'b0, prev_ov = 1'b0;
  int rsp_left = 0, accept_cyc = 0, rise_cyc = 0, hs_cyc = 0;
  int n_accept = 0, n_hs = 0, cmds_fired = 0;

  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rd_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_data(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else if (inject) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = '1;
        inject        = 1'b0;
      end
      mem_rd_ready = 1'b1;
      if (stall_left > 0 && mem_rd_valid && cmds_fired == stall_at) begin
        mem_rd_ready = 1'b0;
        stall_left--;
      end
    end
  end

  // Compare process: checks outputs against the model, then advances it.
  always @(negedge clk) begin
    if (armed) begin
      chk("req_ready", req_ready, !busy);
      chk("mem_rd_valid", mem_rd_valid, cmd_q.size() != 0);
      chk("out_valid", out_valid, m_done);
      chk("out_mask", out_mask, m_mask);
      chk("rsp_err", rsp_err, m_err);
      if (out_valid) chk("out_data", out_data, m_out);
      if (prev_stall && mem_rd_valid) chk("addr_hold", mem_rd_addr, prev_addr);
      if (out_valid && !prev_ov) rise_cyc = cyc;
      prev_ov = out_valid;

      if (!rstn) begin
        busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_mask = '0; m_out = '0; rsp_left = 0;
        cmd_q.delete();
        mem_q.delete();
        prev_stall = 1'b0;
        prev_ov = 1'b0;
      end else begin
        prev_stall = mem_rd_valid && !mem_rd_ready;
        prev_addr  = mem_rd_addr;
        if (mem_rd_valid && mem_rd_ready) begin
          if (cmd_q.size() == 0) begin
            fail("cmd_unexpected");
          end else begin
            chk("cmd_addr", mem_rd_addr, cmd_q[0]);
            void'(cmd_q.pop_front());
          end
          r_tmp.due  = cyc + mem_lat;
          r_tmp.addr = mem_rd_addr;
          mem_q.push_back(r_tmp);
          cmds_fired++;
        end
        if (mem_rsp_valid) begin
          if (busy && rsp_left > 0) begin
            rsp_left--;
            if (rsp_left == 0) m_done = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
        if (out_valid && out_ready) begin
          busy = 1'b0; m_done = 1'b0;
          hs_cyc = cyc; n_hs++;
          last_out = out_data; last_mask = out_mask;
        end
        if (req_valid && req_ready) begin
          busy = 1'b1;
          m_mask = req_mask;
          m_out = '0;
          cmd_q.delete();
          rsp_left = 0;
          for (int i = 0; i < NR; i++) begin
            if (req_mask[i]) begin
              m_out[i*DW +: DW] = mem_data(req_addr[i*AW +: AW]);
              cmd_q.push_back(req_addr[i*AW +: AW]);
              rsp_left++;
            end
          end
          if (rsp_left == 0) m_done = 1'b1;
          accept_cyc = cyc; n_accept++; cmds_fired = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [NR-1:0] mask, input logic [NR*AW-1:0] addrs);
    req_valid = 1'b1;
    req_mask  = mask;
    req_addr  = addrs;
  endtask

  task automatic wait_accept();
    int n0 = n_accept;
    for (int k = 0; k < 50 && n_accept == n0; k++) tick();
    req_valid = 1'b0;
    if (n_accept == n0) fail("accept_timeout");
  endtask

  task automatic wait_hs();
    int n0 = n_hs;
    for (int k = 0; k < 300 && n_hs == n0; k++) tick();
    if (n_hs == n0) fail("handshake_timeout");
  endtask

  task automatic frag(input logic [NR-1:0] mask, input logic [NR*AW-1:0] addrs);
    start_req(mask, addrs);
    wait_accept();
    wait_hs();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_mem_rd_valid"}, mem_rd_valid, 1'b0);
    chk({tag, "_mem_rd_addr"}, mem_rd_addr, '0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_out_mask"}, out_mask, '0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
  endtask

  initial begin
    int n0;
    rstn = 1'b0; req_valid = 1'b0; req_mask = '0; req_addr = '0; out_ready = 1'b1;
    repeat (3) tick();
    rstn  = 1'b1;
    armed = 1'b1;
    chk_reset_outputs("reset");

    // All four RTs, latency 1.
    frag(4'b1111, {32'h400, 32'h300, 32'h200, 32'h100});
    chk("full_latency", rise_cyc - accept_cyc, 6);
    chk("full_cmds", cmds_fired, 4);
    chk("full_lane0", last_out[127:0], {4{32'hDEAD0100}});
    chk("full_lane3", last_out[511:384], {4{32'hDEAD0400}});
    chk("full_mask", last_mask, 4'b1111);

    // Sparse mask: lanes 0 and 2 must stay zero.
    frag(4'b1010, {32'h3000, 32'h0BAD, 32'h1000, 32'h0BAD});
    chk("sparse_cmds", cmds_fired, 2);
    chk("sparse_lane0", last_out[127:0], '0);
    chk("sparse_lane1", last_out[255:128], {4{32'hDEAD1000}});
    chk("sparse_lane2", last_out[383:256], '0);
    chk("sparse_lane3", last_out[511:384], {4{32'hDEAD3000}});
    chk("sparse_latency", rise_cyc - accept_cyc, 4);

    // Empty mask: no memory traffic, result next cycle.
    frag(4'b0000, {4{32'h55}});
    chk("empty_latency", rise_cyc - accept_cyc, 1);
    chk("empty_cmds", cmds_fired, 0);
    chk("empty_data", last_out, '0);
    chk("empty_mask", last_mask, 4'b0000);

    // Single RT: T+3.
    frag(4'b0100, {32'h0, 32'h777, 32'h0, 32'h0});
    chk("single_latency", rise_cyc - accept_cyc, 3);
    chk("single_lane2", last_out[383:256], {4{32'hDEAD0777}});

    // Second command stalled for three cycles.
    stall_at = 1; stall_left = 3;
    frag(4'b1111, {32'h40, 32'h30, 32'h20, 32'h10});
    chk("stall_cmds", cmds_fired, 4);
    chk("stall_used", stall_left, 0);
    chk("stall_latency", rise_cyc - accept_cyc, 9);
    chk("stall_lane1", last_out[255:128], {4{32'hDEAD0020}});
    stall_at = -1;

    // Pipelined memory, latency 3, two RTs: k+L+1 = 6.
    mem_lat = 3;
    frag(4'b0101, {32'h0, 32'h5000, 32'h0, 32'h6000});
    chk("lat3_latency", rise_cyc - accept_cyc, 6);
    chk("lat3_lane0", last_out[127:0], {4{32'hDEAD6000}});
    mem_lat = 1;

    // Output backpressure with a pending request.
    out_ready = 1'b0;
    start_req(4'b0110, {32'h0, 32'hA2, 32'hA1, 32'h0});
    wait_accept();
    for (int k = 0; k < 50 && !out_valid; k++) tick();
    if (!out_valid) fail("hold_out_valid_timeout");
    start_req(4'b1001, {32'hB3, 32'h0, 32'h0, 32'hB0});
    n0 = n_accept;
    repeat (5) tick();
    chk("hold_no_accept", n_accept, n0);
    out_ready = 1'b1;
    wait_hs();
    chk("hold_first_lane1", last_out[255:128], {4{32'hDEAD00A1}});
    wait_accept();
    chk("hold_accept_gap", accept_cyc - hs_cyc, 1);
    wait_hs();
    chk("hold_second_mask", last_mask, 4'b1001);

    // Stray response in IDLE sets the sticky error.
    inject = 1'b1;
    repeat (3) tick();
    chk("err_set", rsp_err, 1'b1);
    frag(4'b0001, {32'h0, 32'h0, 32'h0, 32'hC0});
    chk("err_sticky", rsp_err, 1'b1);

    // Reset in the middle of a fetch.
    mem_lat = 3;
    start_req(4'b1111, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    wait_accept();
    repeat (2) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk_reset_outputs("midreset");
    mem_lat = 1;
    frag(4'b0011, {32'h0, 32'h0, 32'hE1, 32'hE0});
    chk("post_reset_lane0", last_out[127:0], {4{32'hDEAD00E0}});
    chk("post_reset_err", rsp_err, 1'b0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
